pipe_skid_stage: RTL

Parametrised, flow-controlled pipeline stage register replacing the fixed-field, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V core. It holds an opaque payload plus a separate control-bit vector. It provides a valid/ready handshake with a 2-entry skid buffer, so upstream ready never combinationally depends on downstream ready. It also provides a synchronous flush that turns held entries into bubbles, and a saturating back-pressure cycle counter for performance debug.

---
 rtl/pipe_skid_stage_if.sv | 13 +
 rtl/pipe_skid_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage_if.sv
// rtl/pipe_skid_stage_if.sv - valid/ready payload+control handshake bundle
interface pipe_skid_stage_if #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - flow-controlled pipeline register with 2-entry skid, flush and stall counter
module pipe_skid_stage #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_skid_stage_if.slave  in_if,
    pipe_skid_stage_if.master out_if,
    input  logic             flush,
    output logic [1:0]       level,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    // Handshake outputs come straight from state flops so no input reaches them combinationally.
    assign in_ready     = (state_q != ST_FULL);
    assign out_valid    = (state_q != ST_EMPTY);
    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_data_q;
    assign out_if.ctrl  = out_valid ? main_ctrl_q : '0;
    assign level        = state_q;
    assign stall_cnt    = stall_cnt_q;

    assign in_fire  = in_if.valid & in_ready;
    assign out_fire = out_valid & out_if.ready;

    // Next-state: occupancy transitions, flush override, saturating stall counter.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = in_if.data;
                    main_ctrl_d = in_if.ctrl;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_if.data;
                    main_ctrl_d = in_if.ctrl;
                end else if (in_fire) begin
                    state_d     = ST_FULL;
                    skid_data_d = in_if.data;
                    skid_ctrl_d = in_if.ctrl;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush turns held entries into bubbles; payload is left as-is, control is zeroed.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end

        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_if.ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State and storage registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
